// File: rtl/sort_out_packer.sv
// rtl/sort_out_packer.sv - packs sorted records into wide words, buffers them in a FWFT FIFO
// and checks key order and counts records as they arrive.
module sort_out_packer #(
    parameter int DATW     = 64,
    parameter int KEYW     = 32,
    parameter int P_LOG    = 3,
    parameter int FIFO_LOG = 4,
    parameter int SLACK    = 2,
    parameter int ASCEND   = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATW-1:0]           DIN,
    input  logic                      DINEN,
    input  logic                      FLUSH,
    output logic                      FUL,
    output logic [(DATW<<P_LOG)-1:0]  DOT,
    output logic                      DOTEN,
    input  logic                      DOT_RDY,
    output logic                      ERR,
    output logic                      OVF,
    output logic [31:0]               CNT
);
    localparam int LANES = 1 << P_LOG;
    localparam int WORDW = DATW * LANES;
    localparam int DEPTH = 1 << FIFO_LOG;
    localparam logic [P_LOG-1:0]  LAST    = P_LOG'(LANES - 1);
    localparam logic [FIFO_LOG:0] DEPTH_C = (FIFO_LOG+1)'(DEPTH);
    localparam logic [FIFO_LOG:0] FUL_LVL = (FIFO_LOG+1)'(DEPTH - SLACK);

    logic [DATW-1:0]     lanes_q [LANES];
    logic [WORDW-1:0]    mem_q   [DEPTH];
    logic [P_LOG-1:0]    ptr_q, ptr_d;
    logic [FIFO_LOG-1:0] wr_q, rd_q;
    logic [FIFO_LOG:0]   count_q, count_d;
    logic [31:0]         cnt_q;
    logic [KEYW-1:0]     prev_key_q;
    logic                have_ref_q, have_ref_d;
    logic                err_q, ovf_q, ful_q;

    logic [WORDW-1:0]    word_d;
    logic [KEYW-1:0]     key;
    logic                word_done, flush_part, push_req, push_ok, drop, pop, bad_order;

    assign key   = DIN[KEYW-1:0];
    assign DOTEN = (count_q != '0);
    assign DOT   = DOTEN ? mem_q[rd_q] : '0;
    assign FUL   = ful_q;
    assign ERR   = err_q;
    assign OVF   = ovf_q;
    assign CNT   = cnt_q;

    always_comb begin
        word_done  = DINEN && (ptr_q == LAST);
        // A flush pushes only if something is left in the partial word after this cycle's record.
        flush_part = FLUSH && !word_done && (DINEN || (ptr_q != '0));
        push_req   = word_done || flush_part;
        pop        = DOTEN && DOT_RDY;
        push_ok    = push_req && ((count_q != DEPTH_C) || pop);
        drop       = push_req && (count_q == DEPTH_C) && !pop;
        count_d    = count_q + {{FIFO_LOG{1'b0}}, push_ok} - {{FIFO_LOG{1'b0}}, pop};

        if (push_req)   ptr_d = '0;
        else if (DINEN) ptr_d = ptr_q + 1'b1;
        else            ptr_d = ptr_q;

        if (FLUSH)      have_ref_d = 1'b0;
        else if (DINEN) have_ref_d = 1'b1;
        else            have_ref_d = have_ref_q;

        if (ASCEND != 0) bad_order = have_ref_q && (key < prev_key_q);
        else             bad_order = have_ref_q && (key > prev_key_q);

        // Lanes below ptr are held, the lane at ptr takes this cycle's record, the rest pad to ones.
        word_d = '1;
        for (int k = 0; k < LANES; k++) begin
            if (P_LOG'(k) < ptr_q)
                word_d[k*DATW +: DATW] = lanes_q[k];
            else if ((P_LOG'(k) == ptr_q) && DINEN)
                word_d[k*DATW +: DATW] = DIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (DINEN)   lanes_q[ptr_q] <= DIN;
        if (push_ok) mem_q[wr_q]    <= word_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            cnt_q      <= '0;
            prev_key_q <= '0;
            have_ref_q <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            ful_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            have_ref_q <= have_ref_d;
            ful_q      <= (count_d >= FUL_LVL);
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            if (drop)    ovf_q <= 1'b1;
            if (DINEN) begin
                cnt_q      <= cnt_q + 32'd1;
                prev_key_q <= key;
                if (bad_order) err_q <= 1'b1;
            end
        end
    end
endmodule
